// File: rtl/reg_f_stack_ctrl_if.sv
// Bus bundle between the register-file stack controller and its user/RAM side.
// slave is the controller's view; master is the driving side (register file, RAM outputs).
interface reg_f_stack_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 push;
   logic                 pop;
   logic [9*WIDTH-1:0]   stack_q;
   logic [5:0]           addr;
   logic                 wren;
   logic [9*WIDTH-1:0]   restore_data;
   logic                 restore_valid;
   logic                 push_done;
   logic                 busy;
   logic                 full;
   logic                 empty;
   logic                 overflow;
   logic                 underflow;
   logic [6:0]           depth;

   modport slave (
      input  push, pop, stack_q,
      output addr, wren, restore_data, restore_valid, push_done,
             busy, full, empty, overflow, underflow, depth
   );

   modport master (
      output push, pop, stack_q,
      input  addr, wren, restore_data, restore_valid, push_done,
             busy, full, empty, overflow, underflow, depth
   );
endinterface

// File: rtl/reg_f_stack_ctrl.sv
// Save/restore controller for a nine-register file backed by a 64-deep stack RAM.
// Every output is a flop; the comb blocks only compute next values.
module reg_f_stack_ctrl #(
   parameter int WIDTH  = 8,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   reg_f_stack_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, PUSH, POP_WAIT, POP_DONE} state_e;

   state_e             state_q, state_d;
   logic [6:0]         sp_q, sp_d;
   logic [5:0]         addr_q, addr_d;
   logic               wren_q, wren_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [9*WIDTH-1:0] rdata_q, rdata_d;
   logic               rvalid_q, rvalid_d;
   logic               pdone_q, pdone_d;
   logic               busy_q, busy_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.push) begin
               if (!full_q) state_d = PUSH;
            end else if (bus.pop && !empty_q) begin
               state_d = POP_WAIT;
            end
         end
         PUSH:     state_d = IDLE;
         POP_WAIT: if (cnt_q == '0) state_d = POP_DONE;
         POP_DONE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // busy/full/empty are registered from next-state values so they line up with state and sp.
   always_comb begin
      sp_d     = sp_q;
      addr_d   = addr_q;
      wren_d   = 1'b0;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      pdone_d  = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.push) begin
               if (!full_q) begin
                  addr_d = sp_q[5:0];
                  wren_d = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (bus.pop) begin
               if (!empty_q) begin
                  addr_d = 6'(sp_q - 7'd1);
                  cnt_d  = 3'(RD_LAT);
               end else begin
                  unf_d = 1'b1;
               end
            end
         end
         PUSH: begin
            sp_d    = sp_q + 7'd1;
            pdone_d = 1'b1;
         end
         POP_WAIT: begin
            if (cnt_q == '0) rdata_d = bus.stack_q;
            else             cnt_d   = cnt_q - 3'd1;
         end
         POP_DONE: begin
            rvalid_d = 1'b1;
            sp_d     = sp_q - 7'd1;
         end
         default: ;
      endcase
      busy_d  = (state_d != IDLE);
      full_d  = (sp_d == 7'd64);
      empty_d = (sp_d == 7'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q     <= '0;
         addr_q   <= '0;
         wren_q   <= 1'b0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         pdone_q  <= 1'b0;
         busy_q   <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         sp_q     <= sp_d;
         addr_q   <= addr_d;
         wren_q   <= wren_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         pdone_q  <= pdone_d;
         busy_q   <= busy_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign bus.addr          = addr_q;
   assign bus.wren          = wren_q;
   assign bus.restore_data  = rdata_q;
   assign bus.restore_valid = rvalid_q;
   assign bus.push_done     = pdone_q;
   assign bus.busy          = busy_q;
   assign bus.full          = full_q;
   assign bus.empty         = empty_q;
   assign bus.overflow      = ovf_q;
   assign bus.underflow     = unf_q;
   assign bus.depth         = sp_q;

endmodule

// File: tb/tb_reg_f_stack_ctrl.sv
// Randomized scoreboard bench for reg_f_stack_ctrl with a behavioural stack model
// and a latency-accurate stack RAM model.
module tb_reg_f_stack_ctrl;
   localparam int W  = 8;
   localparam int RD = 2;

   typedef struct {
      int               kind;   // 0 push_done, 1 restore, 2 overflow, 3 underflow
      logic [9*W-1:0]   data;
      int               depth;
      int               cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [9*W-1:0] regs;
   logic [9*W-1:0] mem  [64];
   logic [9*W-1:0] pipe [RD];
   logic [9*W-1:0] model [$];
   ev_t            sb [$];

   ev_t mon_e;
   int  mon_kind;
   int  mon_cnt;
   logic rv_seen;

   reg_f_stack_ctrl_if #(.WIDTH(W)) bus ();

   reg_f_stack_ctrl #(.WIDTH(W), .RD_LAT(RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stack RAM: q reflects mem[addr] RD clocks after the edge that applied addr.
   always @(posedge clk) begin
      if (bus.wren) mem[bus.addr] <= regs;
      pipe[0] <= mem[bus.addr];
      for (int i = 1; i < RD; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.stack_q = pipe[RD-1];

   task automatic chk(input string nm, input logic [9*W-1:0] act, input logic [9*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [9*W-1:0] rand_regs();
      logic [9*W-1:0] v;
      for (int i = 0; i < 9; i++) v[i*W +: W] = W'($urandom);
      return v;
   endfunction

   always @(negedge clk) begin
      if (bus.push_done || bus.restore_valid || bus.overflow || bus.underflow) begin
         mon_cnt  = int'(bus.push_done) + int'(bus.restore_valid) + int'(bus.overflow) + int'(bus.underflow);
         mon_kind = bus.push_done ? 0 : bus.restore_valid ? 1 : bus.overflow ? 2 : 3;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, required none", mon_kind, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("single_strobe", mon_cnt, 1);
            chk("ev_kind", mon_kind, mon_e.kind);
            chk("ev_cycle", cyc, mon_e.cyc);
            chk("ev_depth", bus.depth, mon_e.depth);
            if (mon_e.kind == 1) chk("restore_data", bus.restore_data, mon_e.data);
            if (mon_e.kind >= 2) chk("flag_not_busy", bus.busy, 1'b0);
         end
      end
   end

   task automatic issue(input logic p, input logic o, input logic [9*W-1:0] val);
      int req;
      int noise;
      int sz;
      logic [5:0] addr_before;
      @(posedge clk); #1;
      if (p) regs = val;
      bus.push = p;
      bus.pop  = o;
      addr_before = bus.addr;
      sz = model.size();
      @(posedge clk); #1;
      req   = cyc;
      noise = 0;
      if (p) begin
         if (sz < 64) begin
            chk("push_wren", bus.wren, 1'b1);
            chk("push_addr", bus.addr, sz);
            sb.push_back('{0, '0, sz + 1, req + 1});
            model.push_back(val);
            noise = 1;
         end else begin
            chk("ovf_wren", bus.wren, 1'b0);
            chk("ovf_addr", bus.addr, addr_before);
            sb.push_back('{2, '0, 64, req});
         end
      end else if (o) begin
         if (sz > 0) begin
            chk("pop_addr", bus.addr, sz - 1);
            chk("pop_wren", bus.wren, 1'b0);
            sb.push_back('{1, model[sz-1], sz - 1, req + RD + 2});
            void'(model.pop_back());
            noise = RD + 2;
         end else begin
            chk("unf_addr", bus.addr, addr_before);
            chk("unf_busy", bus.busy, 1'b0);
            sb.push_back('{3, '0, 0, req});
         end
      end
      // Requests raised while busy must be dropped, not queued.
      for (int i = 0; i < noise; i++) begin
         bus.push = 1'($urandom);
         bus.pop  = 1'($urandom);
         @(posedge clk); #1;
      end
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      for (int i = 0; i < 12 && bus.busy; i++) begin
         @(posedge clk); #1;
      end
      chk("idle_timeout", bus.busy, 1'b0);
      @(negedge clk);
      chk("idle_depth", bus.depth, model.size());
      chk("idle_empty", bus.empty, model.size() == 0);
      chk("idle_full", bus.full, model.size() == 64);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model.delete();
   endtask

   initial begin
      logic [9*W-1:0] fixed;
      int r;
      rst      = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      regs     = '0;
      @(posedge clk); #1;
      chk("rst_depth", bus.depth, 0);
      chk("rst_empty", bus.empty, 1'b1);
      chk("rst_full", bus.full, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_wren", bus.wren, 1'b0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_rdata", bus.restore_data, 0);
      chk("rst_strobes", {bus.restore_valid, bus.push_done, bus.overflow, bus.underflow}, 0);
      rst = 1'b0;

      issue(1'b0, 1'b1, '0);
      for (int i = 0; i < 9; i++) fixed[i*W +: W] = W'((i + 1) * 8'h11);
      issue(1'b1, 1'b0, fixed);
      issue(1'b1, 1'b0, rand_regs());
      issue(1'b1, 1'b0, rand_regs());
      issue(1'b0, 1'b1, '0);

      while (model.size() < 64) issue(1'b1, 1'b0, rand_regs());
      issue(1'b1, 1'b0, rand_regs());
      issue(1'b1, 1'b1, rand_regs());
      for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, '0);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         issue(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, rand_regs());
      end

      do_reset();
      for (int i = 0; i < 5; i++) issue(1'b1, 1'b0, rand_regs());
      issue(1'b1, 1'b1, rand_regs());

      // Reset while the pop is waiting on the RAM must abort it silently.
      @(posedge clk); #1;
      bus.pop = 1'b1;
      @(posedge clk); #1;
      bus.pop = 1'b0;
      chk("popwait_busy", bus.busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model.delete();
      rv_seen = 1'b0;
      repeat (RD + 4) begin
         @(negedge clk);
         if (bus.restore_valid) rv_seen = 1'b1;
      end
      chk("abort_no_rv", rv_seen, 1'b0);
      chk("abort_depth", bus.depth, 0);
      chk("abort_empty", bus.empty, 1'b1);

      @(posedge clk); #1;
      rst      = 1'b1;
      bus.push = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      bus.push = 1'b0;
      chk("rst_push_busy", bus.busy, 1'b0);
      chk("rst_push_wren", bus.wren, 1'b0);
      chk("rst_push_depth", bus.depth, 0);

      repeat (10) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running at cycle %0d, required finished", cyc);
      $fatal(1, "timeout");
   end
endmodule
